// File: rtl/cape_gpio_irq.sv
// Cape GPIO interrupt controller: per-pin synchroniser, prescaled glitch filter,
// edge detect, sticky W1C pending bits and masked level interrupts behind an APB3 slave.
module cape_gpio_irq #(
  parameter int NUM_GPIO = 28,
  parameter int NUM_INT  = 24,
  parameter int DIV_W    = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [7:0]          PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  input  logic [NUM_GPIO-1:0] GPIO_IN,
  output logic [NUM_INT-1:0]  INT
);

  localparam logic [5:0] A_IN   = 6'h00;
  localparam logic [5:0] A_EN   = 6'h01;
  localparam logic [5:0] A_RISE = 6'h02;
  localparam logic [5:0] A_FALL = 6'h03;
  localparam logic [5:0] A_PEND = 6'h04;
  localparam logic [5:0] A_DIV  = 6'h05;

  logic [NUM_GPIO-1:0] r_s1, r_s2, r_smp, r_filt;
  logic [NUM_GPIO-1:0] r_en, r_rise, r_fall, r_pend;
  logic [DIV_W-1:0]    r_div, r_cnt;
  logic [1:0]          r_vld;
  logic                r_smp_vld;
  logic                r_prime;
  logic [NUM_INT-1:0]  r_int;

  logic                w_wr, w_rd, w_tick;
  logic [5:0]          w_word;
  logic [NUM_GPIO-1:0] w_wdat, w_agree, w_filt_nxt, w_edge, w_w1c;
  logic [NUM_INT-1:0]  w_int_nxt;
  logic                w_unused;

  assign w_wr     = PSEL & PENABLE & PWRITE;
  assign w_rd     = PSEL & ~PWRITE;
  assign w_word   = PADDR[7:2];
  assign w_wdat   = PWDATA[NUM_GPIO-1:0];
  assign w_unused = ^{PADDR[1:0], PWDATA[31:NUM_GPIO]};

  assign w_tick     = (r_cnt == '0);
  assign w_agree    = ~(r_smp ^ r_s2);
  assign w_filt_nxt = w_tick ? ((r_smp & w_agree) | (r_filt & ~w_agree)) : r_filt;
  // No edges until the filter has been loaded from real pin samples once.
  assign w_edge     = {NUM_GPIO{r_prime}} &
                      ((w_filt_nxt & ~r_filt & r_rise) | (~w_filt_nxt & r_filt & r_fall));
  assign w_w1c      = (w_wr && w_word == A_PEND) ? w_wdat : '0;

  assign w_int_nxt[NUM_INT-2:0] = r_pend[NUM_INT-2:0] & r_en[NUM_INT-2:0];
  assign w_int_nxt[NUM_INT-1]   = |(r_pend[NUM_GPIO-1:NUM_INT-1] & r_en[NUM_GPIO-1:NUM_INT-1]);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_en   <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr && w_word == A_EN)   r_en   <= w_wdat;
      if (w_wr && w_word == A_RISE) r_rise <= w_wdat;
      if (w_wr && w_word == A_FALL) r_fall <= w_wdat;
      if (w_wr && w_word == A_DIV) begin
        r_div <= PWDATA[DIV_W-1:0];
        r_cnt <= PWDATA[DIV_W-1:0];
      end else if (w_tick) begin
        r_cnt <= r_div;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // r_vld tracks synchroniser fill; r_smp_vld marks smp holding a real pin sample.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_smp     <= '0;
      r_filt    <= '0;
      r_vld     <= '0;
      r_smp_vld <= 1'b0;
      r_prime   <= 1'b0;
    end else begin
      r_s1   <= GPIO_IN;
      r_s2   <= r_s1;
      r_vld  <= {r_vld[0], 1'b1};
      r_filt <= w_filt_nxt;
      if (w_tick) r_smp <= r_s2;
      if (w_tick && r_vld[1]) r_smp_vld <= 1'b1;
      if (w_tick && r_smp_vld) r_prime <= 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_pend <= '0;
      r_int  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_w1c) | w_edge;
      r_int  <= w_int_nxt;
    end
  end

  assign INT = r_int;

  always_comb begin
    PRDATA = '0;
    if (w_rd && !PRESET) begin
      case (w_word)
        A_IN:    PRDATA = 32'(r_filt);
        A_EN:    PRDATA = 32'(r_en);
        A_RISE:  PRDATA = 32'(r_rise);
        A_FALL:  PRDATA = 32'(r_fall);
        A_PEND:  PRDATA = 32'(r_pend);
        A_DIV:   PRDATA = 32'(r_div);
        default: PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cape_gpio_irq.sv
// Directed bench for cape_gpio_irq: hand-timed pin waveforms and APB accesses
// with expected register and interrupt values worked out cycle by cycle.
module tb_cape_gpio_irq;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic [27:0] gpio;
  logic [23:0] irq;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cape_gpio_irq dut (
    .PCLK(clk), .PRESET(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .GPIO_IN(gpio), .INT(irq)
  );

  localparam logic [7:0] A_IN = 8'h00, A_EN = 8'h04, A_RISE = 8'h08,
                         A_FALL = 8'h0C, A_PEND = 8'h10, A_DIV = 8'h14;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Commits on the second posedge after the call; returns 1ns after that edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    #1;
    d = prdata;
    psel = 1'b0;
    chk(tag, d, exp);
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; gpio = 28'h000_000F;

    step(2);
    chk("rst_int", 32'(irq), 32'h0);
    rchk("rst_in", A_IN, 32'h0);
    rst = 1'b0;
    step(6);
    rchk("prime_in", A_IN, 32'h0000_000F);
    rchk("prime_pend", A_PEND, 32'h0);
    chk("prime_int", 32'(irq), 32'h0);

    wr(A_EN, 32'hFFFF_FFFF);
    rchk("en_width", A_EN, 32'h0FFF_FFFF);
    wr(A_EN, 32'h0);
    wr(A_DIV, 32'h0001_2345);
    rchk("div_width", A_DIV, 32'h0000_2345);
    wr(A_DIV, 32'h0);
    wr(8'h18, 32'hFFFF_FFFF);
    rchk("unmapped", 8'h18, 32'h0);

    gpio = 28'h0;
    step(8);
    rchk("in_low", A_IN, 32'h0);

    // Rising edge on pin 0: PEND four edges after the change, INT one later.
    wr(A_RISE, 32'h1);
    wr(A_EN, 32'h1);
    gpio[0] = 1'b1;
    step(3);
    rchk("lat_pend_early", A_PEND, 32'h0);
    step(1);
    rchk("lat_pend", A_PEND, 32'h1);
    chk("lat_int_early", 32'(irq), 32'h0);
    step(1);
    chk("lat_int", 32'(irq), 32'h1);

    wr(A_PEND, 32'h1);
    rchk("w1c_pend", A_PEND, 32'h0);
    chk("w1c_int_hold", 32'(irq), 32'h1);
    step(1);
    chk("w1c_int", 32'(irq), 32'h0);

    // Falling-edge glitch filter on pin 1.
    gpio[1] = 1'b1;
    step(8);
    wr(A_FALL, 32'h2);
    gpio[1] = 1'b0;
    step(1);
    gpio[1] = 1'b1;
    step(10);
    rchk("fall_1cyc", A_PEND, 32'h0);
    gpio[1] = 1'b0;
    step(3);
    gpio[1] = 1'b1;
    step(10);
    rchk("fall_3cyc", A_PEND, 32'h2);
    wr(A_PEND, 32'h2);
    rchk("fall_clr", A_PEND, 32'h0);

    // DIV=3: ticks on the write edge W and every 4 edges after it.
    wr(A_RISE, 32'h4);
    wr(A_DIV, 32'h3);
    gpio[2] = 1'b1;
    step(5);
    gpio[2] = 1'b0;
    step(10);
    rchk("div3_5cyc", A_PEND, 32'h0);
    wr(A_DIV, 32'h3);
    gpio[2] = 1'b1;
    step(7);
    rchk("div3_pre", A_PEND, 32'h0);
    step(1);
    rchk("div3_9cyc", A_PEND, 32'h4);
    step(1);
    gpio[2] = 1'b0;
    step(12);
    wr(A_DIV, 32'h0);
    wr(A_PEND, 32'h4);

    // Pins 25 and 27 share the top interrupt line.
    wr(A_EN, 32'h0F80_0000);
    wr(A_RISE, 32'h0A00_0000);
    gpio[25] = 1'b1;
    gpio[27] = 1'b1;
    step(8);
    rchk("or_pend", A_PEND, 32'h0A00_0000);
    chk("or_int", 32'(irq), 32'h0080_0000);
    wr(A_EN, 32'h0);
    step(1);
    chk("mask_int", 32'(irq), 32'h0);
    rchk("mask_pend", A_PEND, 32'h0A00_0000);
    wr(A_EN, 32'h0F80_0000);
    step(1);
    chk("unmask_int", 32'(irq), 32'h0080_0000);
    wr(A_PEND, 32'h0200_0000);
    step(1);
    chk("or_one_clr", 32'(irq), 32'h0080_0000);
    rchk("or_one_pend", A_PEND, 32'h0800_0000);
    wr(A_PEND, 32'h0800_0000);
    step(1);
    chk("or_both_clr", 32'(irq), 32'h0);

    // W1C on the same edge that sets PEND[3].
    wr(A_RISE, 32'h8);
    gpio[3] = 1'b1;
    step(2);
    wr(A_PEND, 32'h8);
    rchk("set_wins", A_PEND, 32'h8);
    wr(A_PEND, 32'h8);
    rchk("set_clr", A_PEND, 32'h0);

    // Reset asserted on the commit edge of an IRQ_EN write.
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = A_EN; pwdata = 32'h0000_FFFF;
    @(negedge clk);
    penable = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rst = 1'b0;
    rchk("rst_wr_en", A_EN, 32'h0);
    chk("rst_wr_int", 32'(irq), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
